// File: rtl/ahim_pingpong_loader_pkg.sv
// Shared types and defaults for the ping-pong image loader.
//   LOADER_*      : default parameter values for the loader and its interface
//   w_state_t     : writer FSM states (HPS load side)
//   r_state_t     : reader FSM states (OCR side)
package ahim_pingpong_loader_pkg;

  localparam int LOADER_DATA_WIDTH    = 32;
  localparam int LOADER_BANK_DEPTH    = 4096;
  localparam int LOADER_BANKS_DEFAULT = 2;
  localparam int LOADER_WD_WIDTH      = 16;

  typedef enum logic {
    W_IDLE,
    W_LOAD
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RST,
    R_RUN
  } r_state_t;

endpackage

// File: rtl/ahim_pingpong_loader_if.sv
// Bus bundle between the HPS write channel / OCR read port and the loader.
//   master : HPS + OCR side (drives load control, write data, read address, ocr_done)
//   slave  : loader side (drives waitrequest, status pulses, pixel data, OCR control)
interface ahim_pingpong_loader_if
  import ahim_pingpong_loader_pkg::*;
#(
  parameter int DATA_WIDTH = LOADER_DATA_WIDTH,
  parameter int BANK_DEPTH = LOADER_BANK_DEPTH,
  parameter int NUM_BANKS  = LOADER_BANKS_DEFAULT,
  parameter int WD_WIDTH   = LOADER_WD_WIDTH
);

  localparam int OW = $clog2(BANK_DEPTH);
  localparam int CW = $clog2(NUM_BANKS + 1);

  logic                  Clear_buff;
  logic                  load_start;
  logic [OW:0]           load_len;
  logic [WD_WIDTH-1:0]   wd_conf;
  logic [DATA_WIDTH-1:0] PIO_OUT;
  logic                  write_request;
  logic                  waitrequest_out;
  logic                  load_done;
  logic                  len_error;
  logic                  watchdog_rx_trigger;
  logic [CW-1:0]         full_count;
  logic [OW-1:0]         Pixel_addr;
  logic [DATA_WIDTH-1:0] pixel_in;
  logic [OW-1:0]         ADDR_PIXEL_END;
  logic                  CU_rst;
  logic                  image_loaded;
  logic                  ocr_done;

  modport master (
    output Clear_buff, load_start, load_len, wd_conf, PIO_OUT, write_request,
           Pixel_addr, ocr_done,
    input  waitrequest_out, load_done, len_error, watchdog_rx_trigger, full_count,
           pixel_in, ADDR_PIXEL_END, CU_rst, image_loaded
  );

  modport slave (
    input  Clear_buff, load_start, load_len, wd_conf, PIO_OUT, write_request,
           Pixel_addr, ocr_done,
    output waitrequest_out, load_done, len_error, watchdog_rx_trigger, full_count,
           pixel_in, ADDR_PIXEL_END, CU_rst, image_loaded
  );

endinterface

// File: rtl/ahim_pingpong_loader_pp_bank_ram.sv
// pp_bank_ram: simple dual-port RAM holding all image banks back to back.
//   clk_in, rst_n : clock, async active-low reset (read register only)
//   clr           : synchronous clear of the read register
//   we/wr_addr/wr_data : write port, address = {bank, offset}
//   rd_addr/rd_data    : registered read port, address = {bank, offset}
// The array itself is never reset; only the output register is.
module pp_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8192,
  parameter int AW         = 13
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk_in) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)   rd_data <= '0;
    else if (clr) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ahim_pingpong_loader.sv
// Multi-bank image loader between the HPS PIO write channel and the OCR read port.
// The HPS fills one bank while OCR processes an earlier one; completed banks are
// handed to OCR in FIFO order.
//   clk_in : single clock
//   rst_n  : async active-low reset
//   bus    : ahim_pingpong_loader_if.slave (load control, write port, status,
//            OCR read port and OCR handshake)
//
// Writer FSM
//   state  | meaning
//   W_IDLE | no load in progress, writes stalled
//   W_LOAD | accepting words into wr_bank until the latched length is reached
// Reader FSM
//   state  | meaning
//   R_IDLE | waiting for a published bank
//   R_RST  | one-cycle OCR reset before the image
//   R_RUN  | image_loaded high until ocr_done
module ahim_pingpong_loader
  import ahim_pingpong_loader_pkg::*;
#(
  parameter int DATA_WIDTH = LOADER_DATA_WIDTH,
  parameter int BANK_DEPTH = LOADER_BANK_DEPTH,
  parameter int NUM_BANKS  = LOADER_BANKS_DEFAULT,
  parameter int WD_WIDTH   = LOADER_WD_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_n,
  ahim_pingpong_loader_if.slave  bus
);

  localparam int OW = $clog2(BANK_DEPTH);
  localparam int LW = OW + 1;
  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = $clog2(NUM_BANKS + 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(BANK_DEPTH);
  localparam logic [CW-1:0] BANKS_C   = CW'(NUM_BANKS);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [BW-1:0]       wr_bank, rd_bank;
  logic [LW-1:0]       wr_cnt;
  logic [WD_WIDTH-1:0] wd_cnt;
  logic [LW-1:0]       len_reg [NUM_BANKS];
  logic [CW-1:0]       full_count_q;
  logic [OW-1:0]       addr_end_q;
  logic                load_done_q, len_error_q, wd_trig_q, cu_rst_q, image_loaded_q;

  logic banks_full, waitreq, accept, last_write, len_ok, wd_hit;
  logic start_ok, len_bad, rel_bank;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BW'(1);
  endfunction

  assign banks_full = (full_count_q == BANKS_C);
  assign waitreq    = !((w_state == W_LOAD) && !banks_full);
  assign accept     = bus.write_request && !waitreq;
  assign last_write = accept && ((wr_cnt + LW'(1)) == len_reg[wr_bank]);
  assign len_ok     = (bus.load_len != '0) && (bus.load_len <= DEPTH_L);
  // Full-bank stalls are the reader's fault, not the HPS's, so they don't age the watchdog.
  assign wd_hit     = (bus.wd_conf != '0) && (w_state == W_LOAD) && !accept && !banks_full
                      && (wd_cnt >= bus.wd_conf - WD_WIDTH'(1));
  assign rel_bank   = (r_state == R_RUN) && bus.ocr_done;

  always_comb begin
    w_next   = w_state;
    start_ok = 1'b0;
    len_bad  = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (bus.load_start) begin
          if (len_ok) begin
            w_next   = W_LOAD;
            start_ok = 1'b1;
          end else begin
            len_bad = 1'b1;
          end
        end
      end
      W_LOAD: begin
        if (last_write || wd_hit) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (full_count_q != '0) r_next = R_RST;
      R_RST:   r_next = R_RUN;
      R_RUN:   if (bus.ocr_done) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      w_state        <= W_IDLE;
      r_state        <= R_IDLE;
      load_done_q    <= 1'b0;
      len_error_q    <= 1'b0;
      wd_trig_q      <= 1'b0;
      cu_rst_q       <= 1'b0;
      image_loaded_q <= 1'b0;
    end else if (bus.Clear_buff) begin
      w_state        <= W_IDLE;
      r_state        <= R_IDLE;
      load_done_q    <= 1'b0;
      len_error_q    <= 1'b0;
      wd_trig_q      <= 1'b0;
      cu_rst_q       <= 1'b0;
      image_loaded_q <= 1'b0;
    end else begin
      w_state        <= w_next;
      r_state        <= r_next;
      load_done_q    <= last_write;
      len_error_q    <= len_bad;
      wd_trig_q      <= wd_hit;
      cu_rst_q       <= (r_next == R_RST);
      image_loaded_q <= (r_next == R_RUN);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank      <= '0;
      rd_bank      <= '0;
      wr_cnt       <= '0;
      wd_cnt       <= '0;
      full_count_q <= '0;
      addr_end_q   <= '0;
      for (int i = 0; i < NUM_BANKS; i++) len_reg[i] <= '0;
    end else if (bus.Clear_buff) begin
      wr_bank      <= '0;
      rd_bank      <= '0;
      wr_cnt       <= '0;
      wd_cnt       <= '0;
      full_count_q <= '0;
      addr_end_q   <= '0;
      for (int i = 0; i < NUM_BANKS; i++) len_reg[i] <= '0;
    end else begin
      if (start_ok) begin
        len_reg[wr_bank] <= bus.load_len;
        wr_cnt           <= '0;
        wd_cnt           <= '0;
      end else if (w_state == W_LOAD) begin
        if (accept) begin
          wr_cnt <= wr_cnt + LW'(1);
          wd_cnt <= '0;
        end else if (!banks_full) begin
          wd_cnt <= wd_cnt + WD_WIDTH'(1);
        end
      end
      if (last_write) wr_bank <= next_bank(wr_bank);
      if (rel_bank)   rd_bank <= next_bank(rd_bank);
      // Publish and release in the same cycle cancel out.
      full_count_q <= full_count_q + CW'(last_write) - CW'(rel_bank);
      if ((r_state == R_IDLE) && (r_next == R_RST))
        addr_end_q <= OW'(len_reg[rd_bank] - LW'(1));
    end
  end

  pp_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_BANKS * BANK_DEPTH),
    .AW         (BW + OW)
  ) u_ram (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .clr     (bus.Clear_buff),
    .we      (accept),
    .wr_addr ({wr_bank, wr_cnt[OW-1:0]}),
    .wr_data (bus.PIO_OUT),
    .rd_addr ({rd_bank, bus.Pixel_addr}),
    .rd_data (bus.pixel_in)
  );

  assign bus.waitrequest_out     = waitreq;
  assign bus.load_done           = load_done_q;
  assign bus.len_error           = len_error_q;
  assign bus.watchdog_rx_trigger = wd_trig_q;
  assign bus.full_count          = full_count_q;
  assign bus.ADDR_PIXEL_END      = addr_end_q;
  assign bus.CU_rst              = cu_rst_q;
  assign bus.image_loaded        = image_loaded_q;

endmodule
